// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flappy_pkg
// Purpose : Shared types and helpers for the flappy game stages.
//           Provides the row-mask type, the pipe-field state encoding,
//           the gap LFSR tap constant and the gap-to-wall mask helper
//           (also used by the LED-matrix display driver).
// Revision: 1.0 - initial release
// ============================================================================
package flappy_pkg;

  localparam int FIELD_ROWS = 16;

  typedef logic [FIELD_ROWS-1:0] row_mask_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    OVER = 1'b1
  } field_state_e;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register:
  // feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Solid wall with a gap_h-row hole whose lowest row is base.
  function automatic row_mask_t gap_to_wall(input logic [3:0] base, input int gap_h);
    row_mask_t wall;
    for (int r = 0; r < FIELD_ROWS; r++) begin
      wall[r] = !((r >= int'(base)) && (r < int'(base) + gap_h));
    end
    return wall;
  endfunction

endpackage : flappy_pkg
`default_nettype wire

// File: rtl/gap_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : gap_lfsr
// Purpose : Free-running 8-bit Fibonacci LFSR that picks the gap base row for
//           each new pipe. The raw 4-bit sample is folded so the whole gap
//           always fits inside the field.
// Ports   : clk, reset  - clock and synchronous active-high reset
//           base [3:0]  - folded gap base row for the current clk
//           wall [15:0] - wall mask built from base for the current clk
// Revision: 1.0 - initial release
// ============================================================================
module gap_lfsr
  import flappy_pkg::*;
#(
  parameter int         GAP_H     = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  base,
  output logic [15:0] wall
);

  // Highest legal base is the one whose gap ends exactly at the top row.
  localparam int c_FOLD_LIMIT = FIELD_ROWS - GAP_H;
  localparam int c_FOLD_SUB   = FIELD_ROWS + 1 - GAP_H;

  logic [7:0] r_lfsr;
  logic       w_feedback;
  logic [3:0] w_base;

  assign w_feedback = ^(r_lfsr & LFSR_TAPS);

  // Runs every clk regardless of game state so the gap sequence depends on
  // how long the player took, not just on the number of pipes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_feedback};
    end
  end

  always_comb begin
    w_base = r_lfsr[3:0];
    if (int'(r_lfsr[3:0]) > c_FOLD_LIMIT) begin
      w_base = 4'(int'(r_lfsr[3:0]) - c_FOLD_SUB);
    end
  end

  assign base = w_base;
  assign wall = gap_to_wall(w_base, GAP_H);

endmodule : gap_lfsr
`default_nettype wire

// File: rtl/pipe_field.sv
`default_nettype none
// ============================================================================
// Module  : pipe_field
// Purpose : Scrolling pipe field. Spawns 2-column pipes at the right edge,
//           scrolls them toward the bird column, detects collisions and the
//           bird falling off, keeps the score and serves column data to the
//           display driver.
// Ports   : clk, reset    - clock and synchronous active-high reset
//           scroll_tick   - one-clk pulse, advance the field one column
//           lights [15:0] - bird column from the bird stage (one-hot or zero)
//           disp_col      - display column select
//           disp_rows     - row mask of the selected column (combinational)
//           gameover      - registered, high once the game is over
//           score [7:0]   - pipes passed, saturating at 255
//           pipe_spawn    - one-clk pulse when a pipe's first wall enters
// Revision: 1.0 - initial release
// ============================================================================
module pipe_field
  import flappy_pkg::*;
#(
  parameter int         N_COLS       = 16,
  parameter int         BIRD_COL     = 2,
  parameter int         PIPE_SPACING = 6,
  parameter int         GAP_H        = 3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scroll_tick,
  input  logic [15:0]               lights,
  input  logic [$clog2(N_COLS)-1:0] disp_col,
  output logic [15:0]               disp_rows,
  output logic                      gameover,
  output logic [7:0]                score,
  output logic                      pipe_spawn
);

  localparam int c_CNT_W = $clog2(PIPE_SPACING);

  row_mask_t          r_col [N_COLS];
  field_state_e       r_state;
  field_state_e       w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_base;
  logic [7:0]         r_score;
  logic               r_gameover;
  logic               r_pipe_spawn;

  logic               w_hit;
  logic               w_advance;
  logic               w_pass;
  logic [3:0]         w_base;
  row_mask_t          w_wall;
  row_mask_t          w_new_col;
  row_mask_t          w_disp;

  gap_lfsr #(
    .GAP_H     (GAP_H),
    .LFSR_SEED (LFSR_SEED)
  ) u_gap_lfsr (
    .clk   (clk),
    .reset (reset),
    .base  (w_base),
    .wall  (w_wall)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_gameover <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gameover <= (w_state_nxt == OVER);
    end
  end

  // A hit takes priority over a coincident scroll_tick, so the frame the
  // player died on stays on the display untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_hit       = ((r_col[BIRD_COL] & lights) != '0) || (lights == '0);
    case (r_state)
      RUN: begin
        if (w_hit) begin
          w_state_nxt = OVER;
        end else if (scroll_tick) begin
          w_advance = 1'b1;
        end
      end
      OVER:    w_state_nxt = OVER;
      default: w_state_nxt = RUN;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // The first wall column uses the live LFSR gap; the second reuses the base
  // latched at that moment so both columns share one gap.
  always_comb begin
    w_new_col = '0;
    if (r_cnt == '0) begin
      w_new_col = w_wall;
    end else if (r_cnt == c_CNT_W'(1)) begin
      w_new_col = gap_to_wall(r_base, GAP_H);
    end
  end

  // A pipe is passed when its trailing wall is in the bird column and the
  // column behind it is empty, i.e. the wall leaves on this tick.
  assign w_pass = (r_col[BIRD_COL] != '0) && (r_col[BIRD_COL+1] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_COLS; i++) begin
        r_col[i] <= '0;
      end
      r_cnt        <= '0;
      r_base       <= '0;
      r_score      <= '0;
      r_pipe_spawn <= 1'b0;
    end else begin
      r_pipe_spawn <= w_advance && (r_cnt == '0);
      if (w_advance) begin
        for (int i = 0; i < N_COLS-1; i++) begin
          r_col[i] <= r_col[i+1];
        end
        r_col[N_COLS-1] <= w_new_col;
        if (r_cnt == c_CNT_W'(PIPE_SPACING-1)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
        if (r_cnt == '0) begin
          r_base <= w_base;
        end
        if (w_pass && (r_score != 8'hFF)) begin
          r_score <= r_score + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- display
  always_comb begin
    w_disp = '0;
    if (int'(disp_col) < N_COLS) begin
      w_disp = r_col[disp_col];
    end
  end

  assign disp_rows  = w_disp;
  assign gameover   = r_gameover;
  assign score      = r_score;
  assign pipe_spawn = r_pipe_spawn;

endmodule : pipe_field
`default_nettype wire

// File: tb/tb_pipe_field.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_field
// Purpose : Self-checking directed bench for pipe_field: reset state, gap
//           placement, collision, passing, fall-off, score saturation and
//           mid-run reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_field;

  logic        clk         = 1'b0;
  logic        reset       = 1'b1;
  logic        scroll_tick = 1'b0;
  logic [15:0] lights      = 16'h0100;
  logic [3:0]  disp_col    = 4'd0;
  logic [15:0] disp_rows;
  logic        gameover;
  logic [7:0]  score;
  logic        pipe_spawn;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side view of the run.
  logic [7:0] m_lfsr;
  int         t;              // ticks issued since the last reset
  int         bases [0:511];  // folded gap base of each spawned pipe
  bit         steer;          // keep the bird inside the upcoming gap
  logic       last_spawn;

  pipe_field dut (
    .clk         (clk),
    .reset       (reset),
    .scroll_tick (scroll_tick),
    .lights      (lights),
    .disp_col    (disp_col),
    .disp_rows   (disp_rows),
    .gameover    (gameover),
    .score       (score),
    .pipe_spawn  (pipe_spawn)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, left shift, seed A5.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int fold(input int b);
    return (b > 13) ? b - 14 : b;
  endfunction

  function automatic logic [15:0] wall_of(input int b);
    return 16'hFFFF ^ (16'h0007 << b);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    scroll_tick = 1'b0;
    lights      = 16'h0100;
    steer       = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t     = 0;
  endtask

  task automatic tick();
    logic [7:0] lf;
    int p;
    @(negedge clk);
    scroll_tick = 1'b1;
    lf          = m_lfsr;
    @(negedge clk);
    scroll_tick = 1'b0;
    last_spawn  = pipe_spawn;
    if (t % 6 == 0) bases[t/6] = fold(int'(lf[3:0]));
    t = t + 1;
    if (steer) begin
      p      = (t < 10) ? 0 : (t - 10) / 6;
      lights = 16'(1) << (bases[p] + 1);
    end
  endtask

  task automatic read_col(input int c);
    disp_col = 4'(c);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gameover !== 1'b0) begin n_fail++; $display("FAIL reset_gameover: got %b want 0", gameover); end
    n_checks++;
    if (pipe_spawn !== 1'b0) begin n_fail++; $display("FAIL reset_spawn: got %b want 0", pipe_spawn); end
    repeat (50) @(negedge clk);
    n_checks++;
    if (gameover !== 1'b0) begin n_fail++; $display("FAIL idle_gameover: got %b want 0", gameover); end
    n_checks++;
    if (score !== 8'd0) begin n_fail++; $display("FAIL idle_score: got %0d want 0", score); end
    for (int c = 0; c < 16; c++) begin
      read_col(c);
      n_checks++;
      if (disp_rows !== 16'h0000) begin
        n_fail++; $display("FAIL idle_col%0d: got %h want 0000", c, disp_rows);
      end
    end
  endtask

  task automatic test_gap_placement();
    logic [15:0] w0;
    do_reset();
    tick();
    w0 = wall_of(bases[0]);
    n_checks++;
    if (last_spawn !== 1'b1) begin n_fail++; $display("FAIL gap_spawn_t1: got %b want 1", last_spawn); end
    read_col(15);
    n_checks++;
    if (disp_rows !== w0) begin n_fail++; $display("FAIL gap_col15_t1: got %h want %h", disp_rows, w0); end
    read_col(14);
    n_checks++;
    if (disp_rows !== 16'h0000) begin n_fail++; $display("FAIL gap_col14_t1: got %h want 0000", disp_rows); end
    @(negedge clk);
    n_checks++;
    if (pipe_spawn !== 1'b0) begin n_fail++; $display("FAIL gap_spawn_width: got %b want 0", pipe_spawn); end
    tick();
    n_checks++;
    if (last_spawn !== 1'b0) begin n_fail++; $display("FAIL gap_spawn_t2: got %b want 0", last_spawn); end
    read_col(14);
    n_checks++;
    if (disp_rows !== w0) begin n_fail++; $display("FAIL gap_col14_t2: got %h want %h", disp_rows, w0); end
    read_col(15);
    n_checks++;
    if (disp_rows !== w0) begin n_fail++; $display("FAIL gap_col15_t2: got %h want %h", disp_rows, w0); end
  endtask

  task automatic test_collision();
    logic [15:0] w0;
    int          row;
    do_reset();
    repeat (13) tick();
    w0  = wall_of(bases[0]);
    row = (bases[0] <= 12) ? bases[0] + 3 : bases[0] - 1;
    lights = 16'(1) << row;
    tick();  // tick 14: first wall reaches the bird column
    n_checks++;
    if (gameover !== 1'b0) begin n_fail++; $display("FAIL coll_early: got %b want 0", gameover); end
    @(negedge clk);
    n_checks++;
    if (gameover !== 1'b1) begin n_fail++; $display("FAIL coll_gameover: got %b want 1", gameover); end
    repeat (3) tick();
    read_col(2);
    n_checks++;
    if (disp_rows !== w0) begin n_fail++; $display("FAIL coll_frozen_col2: got %h want %h", disp_rows, w0); end
    read_col(3);
    n_checks++;
    if (disp_rows !== w0) begin n_fail++; $display("FAIL coll_frozen_col3: got %h want %h", disp_rows, w0); end
    read_col(1);
    n_checks++;
    if (disp_rows !== 16'h0000) begin n_fail++; $display("FAIL coll_frozen_col1: got %h want 0000", disp_rows); end
    n_checks++;
    if (score !== 8'd0) begin n_fail++; $display("FAIL coll_score: got %0d want 0", score); end
    n_checks++;
    if (gameover !== 1'b1) begin n_fail++; $display("FAIL coll_hold: got %b want 1", gameover); end
  endtask

  task automatic test_pass();
    do_reset();
    steer = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 6 || k == 7) begin
        n_checks++;
        if (last_spawn !== (k == 7)) begin
          n_fail++; $display("FAIL pass_spawn_t%0d: got %b want %b", k, last_spawn, (k == 7));
        end
      end
      if (k == 15) begin
        n_checks++;
        if (score !== 8'd0) begin n_fail++; $display("FAIL pass_score_t15: got %0d want 0", score); end
      end
    end
    n_checks++;
    if (score !== 8'd1) begin n_fail++; $display("FAIL pass_score_t16: got %0d want 1", score); end
    n_checks++;
    if (gameover !== 1'b0) begin n_fail++; $display("FAIL pass_gameover: got %b want 0", gameover); end
  endtask

  task automatic test_fall_off();
    logic [15:0] w0;
    do_reset();
    tick();
    w0 = wall_of(bases[0]);
    @(negedge clk);
    lights      = 16'h0000;
    scroll_tick = 1'b1;
    @(negedge clk);
    scroll_tick = 1'b0;
    n_checks++;
    if (gameover !== 1'b1) begin n_fail++; $display("FAIL fall_gameover: got %b want 1", gameover); end
    read_col(14);
    n_checks++;
    if (disp_rows !== 16'h0000) begin n_fail++; $display("FAIL fall_noshift_col14: got %h want 0000", disp_rows); end
    read_col(15);
    n_checks++;
    if (disp_rows !== w0) begin n_fail++; $display("FAIL fall_noshift_col15: got %h want %h", disp_rows, w0); end
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    steer = 1'b1;
    for (int k = 1; k <= 1552; k++) begin
      tick();
      if (k == 1534 || k == 1540 || k == 1552) begin
        n_checks++;
        if (score !== ((k == 1534) ? 8'd254 : 8'd255)) begin
          n_fail++; $display("FAIL sat_score_t%0d: got %0d want %0d", k, score, (k == 1534) ? 254 : 255);
        end
      end
    end
    n_checks++;
    if (gameover !== 1'b0) begin n_fail++; $display("FAIL sat_gameover: got %b want 0", gameover); end
    @(negedge clk);
    reset       = 1'b1;
    scroll_tick = 1'b1;
    @(negedge clk);
    scroll_tick = 1'b0;
    n_checks++;
    if (score !== 8'd0) begin n_fail++; $display("FAIL rst_score: got %0d want 0", score); end
    n_checks++;
    if (gameover !== 1'b0) begin n_fail++; $display("FAIL rst_gameover: got %b want 0", gameover); end
    for (int c = 0; c < 16; c++) begin
      read_col(c);
      n_checks++;
      if (disp_rows !== 16'h0000) begin
        n_fail++; $display("FAIL rst_col%0d: got %h want 0000", c, disp_rows);
      end
    end
    reset  = 1'b0;
    steer  = 1'b0;
    lights = 16'h0100;
    t      = 0;
    tick();
    n_checks++;
    if (last_spawn !== 1'b1) begin n_fail++; $display("FAIL rst_respawn: got %b want 1", last_spawn); end
    read_col(15);
    n_checks++;
    if (disp_rows !== wall_of(bases[0])) begin
      n_fail++; $display("FAIL rst_col15: got %h want %h", disp_rows, wall_of(bases[0]));
    end
  endtask

  initial begin
    test_reset();
    test_gap_placement();
    test_collision();
    test_pass();
    test_fall_off();
    test_saturation_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_field
`default_nettype wire
